// File: rtl/axi_mem_tester_if.sv
// AXI4 bus bundle (no ID channels) used between the memory tester and the
// memory-controller slave port.
//   M modport : master side, drives AW/W/AR request fields, bready and rready
//   S modport : slave side, drives the ready signals and the B/R responses
interface AXI #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic [3:0]      awregion;
  logic            awvalid;
  logic            awready;

  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [3:0]      arqos;
  logic [3:0]      arregion;
  logic            arvalid;
  logic            arready;

  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport M (
    output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport S (
    input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_tester.sv
// AXI4 memory traffic generator and checker.
// On an accepted start it writes NUM_BURSTS INCR bursts of a seeded counting
// pattern, reads them all back and compares every beat, then reports the
// result until the next start.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   start           one-cycle pulse, ignored while busy
//   seed            pattern seed, captured on an accepted start
//   busy            test in progress
//   done            test finished, held until the next accepted start
//   pass            done with zero errors
//   err_count       saturating mismatch / error-response count
//   first_err_addr  byte address of the first failure
//   m_axi           AXI4 master port
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start after reset
// AW     | write address issued for the current burst
// W      | streaming write beats of the current burst
// B      | waiting for the write response
// AR     | read address issued for the current burst
// R      | receiving and checking read beats
// DONE   | results valid, waiting for the next start
module axi_mem_tester #(
  parameter int              DW         = 32,
  parameter int              AW         = 32,
  parameter logic [AW-1:0]   BASE_ADDR  = '0,
  parameter int              BURST_LEN  = 16,
  parameter int              NUM_BURSTS = 64
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  AXI.M                 m_axi
);

  localparam int BYTES       = DW / 8;
  localparam int LANES       = DW / 32;
  localparam int BURST_BYTES = BURST_LEN * BYTES;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BCNT_W      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(NUM_BURSTS - 1);
  localparam logic [2:0]        SIZE       = 3'($clog2(BYTES));

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]        state;
  logic [BCNT_W-1:0] burst;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       seed_q;
  logic [15:0]       err_q;
  logic [AW-1:0]     first_q;

  logic [31:0]   word_idx;
  logic [31:0]   exp_word;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] burst_addr;
  logic [AW-1:0] beat_addr;
  logic          is_last_beat;
  logic          is_last_burst;
  logic          b_hs;
  logic          r_hs;
  logic          b_err;
  logic          r_err;
  logic          err_hit;
  logic [AW-1:0] err_addr;

  // The same burst/beat counters serve both the write and the read pass, so
  // the pattern generator and the checker share one datapath.
  assign word_idx      = 32'(burst) * 32'(BURST_LEN) + 32'(beat);
  assign exp_word      = seed_q + word_idx;
  assign exp_data      = {LANES{exp_word}};
  assign burst_addr    = BASE_ADDR + AW'(burst) * AW'(BURST_BYTES);
  assign beat_addr     = burst_addr + AW'(beat) * AW'(BYTES);
  assign is_last_beat  = (beat == LAST_BEAT);
  assign is_last_burst = (burst == LAST_BURST);

  assign b_hs  = (state == S_B) && m_axi.bvalid;
  assign r_hs  = (state == S_R) && m_axi.rvalid;
  assign b_err = b_hs && (m_axi.bresp != 2'b00);
  // A short burst shows up as an early rlast, so rlast is checked per beat.
  assign r_err = r_hs && ((m_axi.rdata != exp_data) ||
                          (m_axi.rresp != 2'b00) ||
                          (m_axi.rlast != is_last_beat));
  assign err_hit  = b_err || r_err;
  assign err_addr = b_err ? burst_addr : beat_addr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      burst   <= '0;
      beat    <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_AW;
            burst   <= '0;
            beat    <= '0;
            seed_q  <= seed;
            err_q   <= '0;
            first_q <= '0;
          end
        end
        S_AW: begin
          if (m_axi.awready) begin
            state <= S_W;
            beat  <= '0;
          end
        end
        S_W: begin
          if (m_axi.wready) begin
            if (is_last_beat) state <= S_B;
            else              beat  <= beat + BEAT_W'(1);
          end
        end
        S_B: begin
          if (m_axi.bvalid) begin
            if (is_last_burst) begin
              state <= S_AR;
              burst <= '0;
            end else begin
              state <= S_AW;
              burst <= burst + BCNT_W'(1);
            end
          end
        end
        S_AR: begin
          if (m_axi.arready) begin
            state <= S_R;
            beat  <= '0;
          end
        end
        S_R: begin
          if (m_axi.rvalid) begin
            if (is_last_beat) begin
              beat <= '0;
              if (is_last_burst) begin
                state <= S_DONE;
              end else begin
                state <= S_AR;
                burst <= burst + BCNT_W'(1);
              end
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // err_q is zero until the first error, so it doubles as the
      // "first error not yet recorded" flag.
      if (err_hit) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (err_q == 16'd0)    first_q <= err_addr;
      end
    end
  end

  assign busy           = (state != S_IDLE) && (state != S_DONE);
  assign done           = (state == S_DONE);
  assign pass           = (state == S_DONE) && (err_q == 16'd0);
  assign err_count      = err_q;
  assign first_err_addr = first_q;

  assign m_axi.awaddr   = burst_addr;
  assign m_axi.awlen    = 8'(BURST_LEN - 1);
  assign m_axi.awsize   = SIZE;
  assign m_axi.awburst  = 2'b01;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = 4'b0011;
  assign m_axi.awprot   = 3'b000;
  assign m_axi.awqos    = 4'b0000;
  assign m_axi.awregion = 4'b0000;
  assign m_axi.awvalid  = (state == S_AW);

  assign m_axi.wdata    = exp_data;
  assign m_axi.wstrb    = '1;
  assign m_axi.wlast    = (state == S_W) && is_last_beat;
  assign m_axi.wvalid   = (state == S_W);

  assign m_axi.bready   = (state == S_B);

  assign m_axi.araddr   = burst_addr;
  assign m_axi.arlen    = 8'(BURST_LEN - 1);
  assign m_axi.arsize   = SIZE;
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'b0011;
  assign m_axi.arprot   = 3'b000;
  assign m_axi.arqos    = 4'b0000;
  assign m_axi.arregion = 4'b0000;
  assign m_axi.arvalid  = (state == S_AR);

  assign m_axi.rready   = (state == S_R);

endmodule
